// File: rtl/svp_dump_formatter_if.sv
// Sample-capture and record-stream bundle for svp_dump_formatter.
// The master side feeds samples and accepts records; the formatter is the slave.
`timescale 1ns/1ps
interface svp_dump_formatter_if #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 1
);
    logic                    sample_valid;
    logic [WIDTH*SIZE-1:0]   sample_data;
    logic                    sample_ready;
    logic                    rec_valid;
    logic                    rec_ready;
    logic [63:0]             rec_data;
    logic [7:0]              rec_chan;
    logic [15:0]             rec_idx;
    logic                    rec_last;
    logic [31:0]             rec_seq;
    logic [15:0]             drop_cnt;

    modport master (
        output sample_valid, sample_data, rec_ready,
        input  sample_ready, rec_valid, rec_data, rec_chan, rec_idx,
               rec_last, rec_seq, drop_cnt
    );

    modport slave (
        input  sample_valid, sample_data, rec_ready,
        output sample_ready, rec_valid, rec_data, rec_chan, rec_idx,
               rec_last, rec_seq, drop_cnt
    );
endinterface

// File: rtl/svp_dump_formatter.sv
// Captures one packed sample per strobe and streams its elements out as
// 64-bit sign/zero-extended records tagged with channel, index and sequence.
`timescale 1ns/1ps
module svp_dump_formatter #(
    parameter int WIDTH   = 8,
    parameter int SIZE    = 1,
    parameter int SIGNED  = 0,
    parameter int CHAN_ID = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    svp_dump_formatter_if.slave     bus
);

    localparam int          DW       = WIDTH * SIZE;
    localparam logic [15:0] LAST_IDX = 16'(SIZE - 1);
    // Upper bits filled by sign extension; empty when the element is already 64 bits.
    localparam logic [63:0] EXT_MASK = (WIDTH >= 64) ? 64'd0 : ~((64'd1 << WIDTH) - 64'd1);

    function automatic logic [WIDTH-1:0] pick(input logic [DW-1:0] v, input logic [15:0] idx);
        logic [DW-1:0] sh;
        sh = v >> (32'(idx) * 32'(WIDTH));
        return sh[WIDTH-1:0];
    endfunction

    function automatic logic [63:0] extend(input logic [WIDTH-1:0] e);
        logic [63:0] r;
        r = 64'd0;
        r[WIDTH-1:0] = e;
        if ((SIGNED != 0) && e[WIDTH-1]) begin
            r = r | EXT_MASK;
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic            busy_r;
    logic            last_r;
    logic [15:0]     idx_r;
    logic [15:0]     drop_r;
    logic [31:0]     seq_r;
    logic [63:0]     data_r;
    logic [DW-1:0]   buf_r;

    logic            xfer_s;
    logic            done_s;
    logic            ready_s;
    logic            cap_s;
    logic            drop_s;
    logic [15:0]     nxt_idx_s;
    logic [63:0]     cap_data_s;
    logic [63:0]     nxt_data_s;

    // Handshake decode and next-record data for both capture and advance paths.
    always_comb begin
        xfer_s     = busy_r & bus.rec_ready;
        done_s     = xfer_s & last_r;
        ready_s    = ~rst & (~busy_r | done_s);
        cap_s      = bus.sample_valid & ready_s;
        drop_s     = bus.sample_valid & ~ready_s;
        nxt_idx_s  = idx_r + 16'd1;
        cap_data_s = extend(pick(bus.sample_data, 16'd0));
        nxt_data_s = extend(pick(buf_r, nxt_idx_s));
    end

    // Sample buffer, emission state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            last_r <= 1'b0;
            idx_r  <= 16'd0;
            drop_r <= 16'd0;
            seq_r  <= 32'd0;
            data_r <= 64'd0;
            buf_r  <= '0;
        end else begin
            if (drop_s && (drop_r != 16'hFFFF)) begin
                drop_r <= drop_r + 16'd1;
            end else begin
                drop_r <= drop_r;
            end

            if (done_s) begin
                seq_r <= seq_r + 32'd1;
            end else begin
                seq_r <= seq_r;
            end

            // A capture wins over going idle so back-to-back samples need no bubble.
            if (cap_s) begin
                buf_r  <= bus.sample_data;
                busy_r <= 1'b1;
                idx_r  <= 16'd0;
                last_r <= (LAST_IDX == 16'd0);
                data_r <= cap_data_s;
            end else if (done_s) begin
                busy_r <= 1'b0;
                idx_r  <= 16'd0;
                last_r <= 1'b0;
            end else if (xfer_s) begin
                idx_r  <= nxt_idx_s;
                last_r <= (nxt_idx_s == LAST_IDX);
                data_r <= nxt_data_s;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign bus.sample_ready = ready_s;
    assign bus.rec_valid    = busy_r;
    assign bus.rec_data     = data_r;
    assign bus.rec_chan     = 8'(CHAN_ID);
    assign bus.rec_idx      = idx_r;
    assign bus.rec_last     = last_r;
    assign bus.rec_seq      = seq_r;
    assign bus.drop_cnt     = drop_r;

endmodule

// File: tb/tb_svp_dump_formatter.sv
// Directed bench: extension table over several parameterisations plus
// hand-written array, back-to-back, backpressure and mid-array reset sequences.
`timescale 1ns/1ps
module tb_svp_dump_formatter;

    logic clk;
    logic rst;
    logic [5:0]  sv;
    logic [5:0]  rr;
    logic [63:0] sd [6];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        valid;
        logic        sready;
        logic        last;
        logic [15:0] idx;
        logic [63:0] data;
        logic [31:0] seq;
        logic [15:0] drop;
        logic [7:0]  chan;
    } obs_t;
    obs_t obs [6];

    typedef struct {
        int          unit;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;
    vec_t tv [11];

    int          seq_m [6];
    logic [7:0]  chan_m [6];

    svp_dump_formatter_if #(.WIDTH(6),  .SIZE(1)) bus0 ();
    svp_dump_formatter_if #(.WIDTH(6),  .SIZE(1)) bus1 ();
    svp_dump_formatter_if #(.WIDTH(14), .SIZE(1)) bus2 ();
    svp_dump_formatter_if #(.WIDTH(21), .SIZE(2)) bus3 ();
    svp_dump_formatter_if #(.WIDTH(8),  .SIZE(4)) bus4 ();
    svp_dump_formatter_if #(.WIDTH(41), .SIZE(1)) bus5 ();

    svp_dump_formatter #(.WIDTH(6),  .SIZE(1), .SIGNED(0), .CHAN_ID(8'h10)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    svp_dump_formatter #(.WIDTH(6),  .SIZE(1), .SIGNED(1), .CHAN_ID(8'h11)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    svp_dump_formatter #(.WIDTH(14), .SIZE(1), .SIGNED(1), .CHAN_ID(8'h12)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    svp_dump_formatter #(.WIDTH(21), .SIZE(2), .SIGNED(0), .CHAN_ID(8'h13)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    svp_dump_formatter #(.WIDTH(8),  .SIZE(4), .SIGNED(1), .CHAN_ID(8'h5A)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    svp_dump_formatter #(.WIDTH(41), .SIZE(1), .SIGNED(0), .CHAN_ID(8'h03)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    assign bus0.sample_valid = sv[0]; assign bus0.rec_ready = rr[0]; assign bus0.sample_data = sd[0][5:0];
    assign bus1.sample_valid = sv[1]; assign bus1.rec_ready = rr[1]; assign bus1.sample_data = sd[1][5:0];
    assign bus2.sample_valid = sv[2]; assign bus2.rec_ready = rr[2]; assign bus2.sample_data = sd[2][13:0];
    assign bus3.sample_valid = sv[3]; assign bus3.rec_ready = rr[3]; assign bus3.sample_data = sd[3][41:0];
    assign bus4.sample_valid = sv[4]; assign bus4.rec_ready = rr[4]; assign bus4.sample_data = sd[4][31:0];
    assign bus5.sample_valid = sv[5]; assign bus5.rec_ready = rr[5]; assign bus5.sample_data = sd[5][40:0];

    assign obs[0] = '{bus0.rec_valid, bus0.sample_ready, bus0.rec_last, bus0.rec_idx, bus0.rec_data, bus0.rec_seq, bus0.drop_cnt, bus0.rec_chan};
    assign obs[1] = '{bus1.rec_valid, bus1.sample_ready, bus1.rec_last, bus1.rec_idx, bus1.rec_data, bus1.rec_seq, bus1.drop_cnt, bus1.rec_chan};
    assign obs[2] = '{bus2.rec_valid, bus2.sample_ready, bus2.rec_last, bus2.rec_idx, bus2.rec_data, bus2.rec_seq, bus2.drop_cnt, bus2.rec_chan};
    assign obs[3] = '{bus3.rec_valid, bus3.sample_ready, bus3.rec_last, bus3.rec_idx, bus3.rec_data, bus3.rec_seq, bus3.drop_cnt, bus3.rec_chan};
    assign obs[4] = '{bus4.rec_valid, bus4.sample_ready, bus4.rec_last, bus4.rec_idx, bus4.rec_data, bus4.rec_seq, bus4.drop_cnt, bus4.rec_chan};
    assign obs[5] = '{bus5.rec_valid, bus5.sample_ready, bus5.rec_last, bus5.rec_idx, bus5.rec_data, bus5.rec_seq, bus5.drop_cnt, bus5.rec_chan};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec_chk(input string tag, input int u, input logic valid, input logic [15:0] idx,
                           input logic last, input logic [63:0] data, input logic [31:0] seq);
        obs_t o;
        o = obs[u];
        chk($sformatf("%s_valid_u%0d", tag, u), 64'(o.valid), 64'(valid));
        chk($sformatf("%s_seq_u%0d", tag, u), 64'(o.seq), 64'(seq));
        if (valid) begin
            chk($sformatf("%s_idx_u%0d", tag, u), 64'(o.idx), 64'(idx));
            chk($sformatf("%s_last_u%0d", tag, u), 64'(o.last), 64'(last));
            chk($sformatf("%s_data_u%0d", tag, u), o.data, data);
            chk($sformatf("%s_chan_u%0d", tag, u), 64'(o.chan), 64'(chan_m[u]));
        end
    endtask

    initial begin
        tv[0]  = '{0, 64'h3F,            64'd63};
        tv[1]  = '{1, 64'h3F,            64'hFFFF_FFFF_FFFF_FFFF};
        tv[2]  = '{0, 64'h1F,            64'd31};
        tv[3]  = '{1, 64'h1F,            64'd31};
        tv[4]  = '{1, 64'h20,            64'hFFFF_FFFF_FFFF_FFE0};
        tv[5]  = '{2, 64'h2000,          64'hFFFF_FFFF_FFFF_E000};
        tv[6]  = '{2, 64'h1FFF,          64'd8191};
        tv[7]  = '{2, 64'h3FFF,          64'hFFFF_FFFF_FFFF_FFFF};
        tv[8]  = '{5, 64'h100_0000_0001, 64'h0000_0100_0000_0001};
        tv[9]  = '{5, 64'h1FF_FFFF_FFFF, 64'h0000_01FF_FFFF_FFFF};
        tv[10] = '{0, 64'h00,            64'd0};
        chan_m[0] = 8'h10; chan_m[1] = 8'h11; chan_m[2] = 8'h12;
        chan_m[3] = 8'h13; chan_m[4] = 8'h5A; chan_m[5] = 8'h03;
        for (int u = 0; u < 6; u++) begin
            seq_m[u] = 0;
            sd[u] = 64'd0;
        end
        sv  = 6'd0;
        rr  = 6'h3F;
        rst = 1'b1;

        // Reset state, then ready after release.
        tick();
        tick();
        for (int u = 0; u < 6; u++) begin
            chk($sformatf("rst_sready_u%0d", u), 64'(obs[u].sready), 64'd0);
            chk($sformatf("rst_data_u%0d", u), obs[u].data, 64'd0);
            chk($sformatf("rst_idx_u%0d", u), 64'(obs[u].idx), 64'd0);
            chk($sformatf("rst_last_u%0d", u), 64'(obs[u].last), 64'd0);
            chk($sformatf("rst_drop_u%0d", u), 64'(obs[u].drop), 64'd0);
            rec_chk("rst", u, 1'b0, 16'd0, 1'b0, 64'd0, 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int u = 0; u < 6; u++) begin
            chk($sformatf("rel_sready_u%0d", u), 64'(obs[u].sready), 64'd1);
        end
        tick();

        // Extension table on single-element units.
        for (int i = 0; i < 11; i++) begin
            int u;
            u = tv[i].unit;
            sd[u] = tv[i].din;
            sv[u] = 1'b1;
            tick();
            sv[u] = 1'b0;
            rec_chk($sformatf("tv%0d", i), u, 1'b1, 16'd0, 1'b1, tv[i].exp, 32'(seq_m[u]));
            tick();
            seq_m[u]++;
            rec_chk($sformatf("tv%0d_done", i), u, 1'b0, 16'd0, 1'b0, 64'd0, 32'(seq_m[u]));
        end

        // SIZE=1 back-to-back strobes: both accepted, no drops.
        sd[0] = 64'h11; sv[0] = 1'b1;
        tick();
        sd[0] = 64'h22;
        chk("b2b_sready", 64'(obs[0].sready), 64'd1);
        rec_chk("b2b_a", 0, 1'b1, 16'd0, 1'b1, 64'h11, 32'(seq_m[0]));
        tick();
        sv[0] = 1'b0;
        seq_m[0]++;
        rec_chk("b2b_b", 0, 1'b1, 16'd0, 1'b1, 64'h22, 32'(seq_m[0]));
        chk("b2b_drop", 64'(obs[0].drop), 64'd0);
        tick();
        seq_m[0]++;
        rec_chk("b2b_idle", 0, 1'b0, 16'd0, 1'b0, 64'd0, 32'(seq_m[0]));

        // WIDTH=21 SIZE=2: two elements, then a sample loaded on the last transfer.
        sd[3] = {22'd0, 21'd4, 21'd5}; sv[3] = 1'b1;
        tick();
        sv[3] = 1'b0;
        rec_chk("s2_e0", 3, 1'b1, 16'd0, 1'b0, 64'd5, 32'd0);
        tick();
        rec_chk("s2_e1", 3, 1'b1, 16'd1, 1'b1, 64'd4, 32'd0);
        chk("s2_sready_last", 64'(obs[3].sready), 64'd1);
        sd[3] = {22'd0, 21'h1F_FFFF, 21'd7}; sv[3] = 1'b1;
        tick();
        sv[3] = 1'b0;
        rec_chk("s2_n0", 3, 1'b1, 16'd0, 1'b0, 64'd7, 32'd1);
        chk("s2_sready_mid", 64'(obs[3].sready), 64'd0);
        tick();
        rec_chk("s2_n1", 3, 1'b1, 16'd1, 1'b1, 64'h1F_FFFF, 32'd1);
        tick();
        rec_chk("s2_idle", 3, 1'b0, 16'd0, 1'b0, 64'd0, 32'd2);
        chk("s2_drop", 64'(obs[3].drop), 64'd0);

        // WIDTH=8 SIZE=4 signed, with one strobe dropped mid-array.
        sd[4] = 64'h8382_8180; sv[4] = 1'b1;
        tick();
        sv[4] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rec_chk($sformatf("s4_e%0d", i), 4, 1'b1, 16'(i), (i == 3), 64'hFFFF_FFFF_FFFF_FF80 + 64'(i), 32'd0);
            if (i == 1) begin
                sd[4] = 64'h1111_1111; sv[4] = 1'b1;
            end else begin
                sv[4] = 1'b0;
            end
            if (i == 2) chk("s4_drop_mid", 64'(obs[4].drop), 64'd1);
            tick();
        end
        rec_chk("s4_idle", 4, 1'b0, 16'd0, 1'b0, 64'd0, 32'd1);
        chk("s4_drop_end", 64'(obs[4].drop), 64'd1);

        // Backpressure, WIDTH=41 SIZE=1: strobe every cycle with rec_ready low.
        rr[5] = 1'b0;
        sd[5] = 64'h0AB_CDEF_1234; sv[5] = 1'b1;
        tick();
        sd[5] = 64'h155_5555_5555;
        for (int i = 1; i <= 3; i++) begin
            rec_chk($sformatf("bp_hold%0d", i), 5, 1'b1, 16'd0, 1'b1, 64'h0AB_CDEF_1234, 32'(seq_m[5]));
            chk($sformatf("bp_sready%0d", i), 64'(obs[5].sready), 64'd0);
            tick();
            chk($sformatf("bp_drop%0d", i), 64'(obs[5].drop), 64'(i));
        end
        sv[5] = 1'b0;
        rr[5] = 1'b1;
        rec_chk("bp_held", 5, 1'b1, 16'd0, 1'b1, 64'h0AB_CDEF_1234, 32'(seq_m[5]));
        tick();
        seq_m[5]++;
        rec_chk("bp_done", 5, 1'b0, 16'd0, 1'b0, 64'd0, 32'(seq_m[5]));
        chk("bp_drop_final", 64'(obs[5].drop), 64'd3);

        // Reset after index 1 of a SIZE=4 sample has transferred.
        sd[4] = 64'h0403_0201; sv[4] = 1'b1;
        tick();
        sv[4] = 1'b0;
        rec_chk("mr_e0", 4, 1'b1, 16'd0, 1'b0, 64'd1, 32'd1);
        tick();
        rec_chk("mr_e1", 4, 1'b1, 16'd1, 1'b0, 64'd2, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        rec_chk("mr_rst", 4, 1'b0, 16'd0, 1'b0, 64'd0, 32'd0);
        chk("mr_rst_idx", 64'(obs[4].idx), 64'd0);
        chk("mr_rst_drop", 64'(obs[4].drop), 64'd0);
        chk("mr_rst_sready", 64'(obs[4].sready), 64'd0);
        chk("mr_rst_drop_u5", 64'(obs[5].drop), 64'd0);
        tick();
        rst = 1'b0;
        sd[4] = 64'h7F7E_7D7C; sv[4] = 1'b1;
        tick();
        sv[4] = 1'b0;
        rec_chk("mr_n0", 4, 1'b1, 16'd0, 1'b0, 64'h7C, 32'd0);
        tick();
        rec_chk("mr_n1", 4, 1'b1, 16'd1, 1'b0, 64'h7D, 32'd0);
        tick();
        tick();
        rec_chk("mr_n3", 4, 1'b1, 16'd3, 1'b1, 64'h7F, 32'd0);
        tick();
        rec_chk("mr_idle", 4, 1'b0, 16'd0, 1'b0, 64'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/svp_dump_formatter.md
Name: svp_dump_formatter

Overview:
- Capture block that sits between design signals and the simulation dump sink.
- Latches one packed bit-vector sample per strobe; the sample is scalar when SIZE=1 and an array of SIZE elements otherwise.
- Sign- or zero-extends each element to a 64-bit record.
- Emits records one element per cycle over a valid/ready stream, tagged with channel, element index and sample sequence number.

Parameters:
- WIDTH, 8: bits per element, legal 1..64.
- SIZE, 1: elements per sample, legal 1..65535.
- SIGNED, 0: 1 = two's-complement sign extension, 0 = zero extension.
- CHAN_ID, 0: 8-bit channel tag copied onto every record.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sample_valid  input  1  one-cycle capture strobe; not held by the source.
- sample_data  input  WIDTH*SIZE  element i at bits [i*WIDTH +: WIDTH].
- sample_ready  output  1  block can accept a sample this cycle.
- rec_valid  output  1  record present.
- rec_ready  input  1  sink accepts the record.
- rec_data  output  64  extended element value.
- rec_chan  output  8  equals CHAN_ID.
- rec_idx  output  16  element index, 0..SIZE-1.
- rec_last  output  1  high when rec_idx = SIZE-1.
- rec_seq  output  32  sample sequence number.
- drop_cnt  output  16  samples lost while not ready.

Behaviour:
- Reset (async assert, sync-released at clk):
  - rec_valid=0, rec_idx=0, rec_last=0, rec_data=0, rec_seq=0, drop_cnt=0.
  - Buffer is empty; sample_ready forced to 0 while rst=1.
- Reset asserted mid-operation discards the buffered sample and clears all counters.
- sample_ready = !busy | (rec_valid & rec_ready & rec_last). This is combinational and allows back-to-back samples with no bubble.
- Capture: at a clk edge with sample_valid & sample_ready:
  - the full sample_data vector is registered;
  - busy=1, rec_valid=1 from the next cycle, rec_idx=0.
- Capture latency: 1 cycle from strobe to first record.
- Drop: sample_valid & !sample_ready means the sample is discarded and drop_cnt increments, saturating at 0xFFFF.
- Emission:
  - rec_data = extend(element[rec_idx]).
  - If SIGNED=1, bit WIDTH-1 is replicated into bits 63..WIDTH.
  - If SIGNED=0, bits 63..WIDTH are zero.
  - If WIDTH=64, no extension is applied.
- Transfer occurs on rec_valid & rec_ready:
  - if !rec_last, rec_idx increments;
  - if rec_last, rec_seq increments (wraps 2^32-1 to 0) and the block either goes idle (rec_valid=0) or loads a simultaneously captured sample with rec_idx=0.
- Backpressure: while rec_valid & !rec_ready, all rec_* outputs hold stable and the buffered sample is unchanged.
- rec_seq on every record equals the number of samples fully emitted before this sample.
- SIZE=1: every record has rec_last=1 and rec_idx=0; sustained throughput is 1 sample/cycle with rec_ready tied high.
- SIZE>1: throughput is 1 sample per SIZE cycles; strobes arriving faster are counted as drops.
- rec_chan is constant CHAN_ID.

Test Plan:
- WIDTH=6, SIGNED=0 vs SIGNED=1, sample 6'h3F:
  - unsigned -> rec_data=63;
  - signed -> rec_data=64'hFFFF_FFFF_FFFF_FFFF;
  - sample 6'h1F -> 31 in both.
- WIDTH=14, SIGNED=1, sample 14'h2000 -> rec_data=-8192 (64'hFFFF_FFFF_FFFF_E000); sample 14'h1FFF -> 8191.
- WIDTH=21, SIZE=2, SIGNED=0, element0=5, element1=4, rec_ready=1:
  - cycle+1: rec_idx=0, rec_data=5, rec_last=0;
  - cycle+2: rec_idx=1, rec_data=4, rec_last=1;
  - next sample carries rec_seq=1.
- WIDTH=8, SIZE=4, SIGNED=1, elements {128,129,130,131} -> rec_data -128, -127, -126, -125 in index order.
- Backpressure, SIZE=1, WIDTH=41: hold rec_ready=0 for 3 cycles while strobing each cycle:
  - first record's rec_data/rec_seq stay stable;
  - drop_cnt=3;
  - after rec_ready=1 the held record transfers and rec_seq increments to 1.
- Reset mid-array, SIZE=4: assert rst after idx=1 is transferred -> rec_valid=0 immediately, rec_seq=0, drop_cnt=0; after release the next strobe emits from rec_idx=0.
